// File: rtl/seven_seg_capture.sv
// Recovers the hex digits shown on a multiplexed, active-low seven-segment bus.
// Each position commits once its {an_n, seg_n} pattern has been stable long enough.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    conflict,
    output logic                    upd,
    output logic [IW-1:0]           upd_idx
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic [SW-1:0] sp;
    logic [CW-1:0] cnt;

    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] en;
    logic                  en_one;
    logic                  en_multi;
    logic [IW-1:0]         sel_idx;
    logic                  commit;
    logic                  dec_ok;
    logic [3:0]            dec_code;
    logic                  blank;

    // Decoding works on sp, which equals s2 whenever commit can fire.
    assign seg      = sp[6:0];
    assign en       = ~sp[SW-1:7];
    assign en_multi = (en & (en - NUM_DIGITS'(1))) != '0;
    assign en_one   = (en != '0) && !en_multi;
    assign blank    = (seg == 7'b1111111);
    assign commit   = (s2 == sp) && (cnt == CNT_PRE);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    always_comb begin
        dec_ok   = 1'b1;
        dec_code = 4'h0;
        case (seg)
            7'b1000000: dec_code = 4'h0;
            7'b1111001: dec_code = 4'h1;
            7'b0100100: dec_code = 4'h2;
            7'b0110000: dec_code = 4'h3;
            7'b0011001: dec_code = 4'h4;
            7'b0010010: dec_code = 4'h5;
            7'b1000010: dec_code = 4'h6;
            7'b0000010: dec_code = 4'h6;
            7'b1111000: dec_code = 4'h7;
            7'b0000000: dec_code = 4'h8;
            7'b0010000: dec_code = 4'h9;
            7'b0001000: dec_code = 4'hA;
            7'b0000011: dec_code = 4'hB;
            7'b1000110: dec_code = 4'hC;
            7'b0100001: dec_code = 4'hD;
            7'b0000110: dec_code = 4'hE;
            7'b0001110: dec_code = 4'hF;
            default:    dec_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= '1;
            s2  <= '1;
            sp  <= '1;
            cnt <= '0;
        end else begin
            s1 <= {an_n, seg_n};
            s2 <= s1;
            sp <= s2;
            if (s2 != sp) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            conflict    <= 1'b0;
            upd         <= 1'b0;
            upd_idx     <= '0;
        end else begin
            upd <= 1'b0;
            if (clear) begin
                digits      <= '0;
                digit_valid <= '0;
                digit_err   <= '0;
                conflict    <= 1'b0;
            end else if (commit) begin
                if (en_multi) begin
                    conflict <= 1'b1;
                end else if (en_one) begin
                    if (blank) begin
                        digit_valid <= digit_valid & ~en;
                        upd         <= 1'b1;
                        upd_idx     <= sel_idx;
                    end else if (dec_ok) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (en[i]) begin
                                digits[4*i +: 4] <= dec_code;
                            end
                        end
                        digit_valid <= digit_valid | en;
                        upd         <= 1'b1;
                        upd_idx     <= sel_idx;
                    end else begin
                        digit_err <= digit_err | en;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios then random display traffic,
// checked every edge against a run-length reference model.
module tb_seven_seg_capture;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int IW = 2;
    localparam int SW = N + 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [6:0]     seg_n;
    logic [N-1:0]   an_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digit_valid;
    logic [N-1:0]   digit_err;
    logic           conflict;
    logic           upd;
    logic [IW-1:0]  upd_idx;

    seven_seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .clear(clear), .seg_n(seg_n), .an_n(an_n),
        .digits(digits), .digit_valid(digit_valid), .digit_err(digit_err),
        .conflict(conflict), .upd(upd), .upd_idx(upd_idx)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [6:0] pats [17] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b1000010, 7'b0000010, 7'b1111000, 7'b0000000,
        7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
        7'b0000110, 7'b0001110
    };
    int codes [17] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

    typedef struct {
        logic [SW-1:0] v;
        int            run;
    } samp_t;

    logic [3:0]    m_dig [N];
    logic [N-1:0]  m_valid;
    logic [N-1:0]  m_err;
    logic          m_conf;
    logic          m_upd;
    logic [IW-1:0] m_idx;
    samp_t         pipe [$];
    logic [SW-1:0] last_v;
    int            last_run;

    int            upd_cnt;
    int            first_edge;
    int            edge_no;
    logic [IW-1:0] idxq [$];

    // -1 blank, -2 illegal, otherwise the hex value shown
    function automatic int lookup(input logic [6:0] p);
        if (p == 7'b1111111) return -1;
        for (int i = 0; i < 17; i++) begin
            if (pats[i] == p) return codes[i];
        end
        return -2;
    endfunction

    task automatic model_reset();
        samp_t z;
        for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
        m_valid = '0;
        m_err   = '0;
        m_conf  = 1'b0;
        m_upd   = 1'b0;
        m_idx   = '0;
        pipe.delete();
        z.v   = '1;
        z.run = 0;
        pipe.push_back(z);
        pipe.push_back(z);
        last_v   = '1;
        last_run = 0;
    endtask

    task automatic model_apply(input logic [SW-1:0] v);
        logic [N-1:0] an;
        int lows;
        int pos;
        int r;
        an   = v[SW-1:7];
        lows = 0;
        pos  = 0;
        for (int i = 0; i < N; i++) begin
            if (!an[i]) begin
                lows++;
                pos = i;
            end
        end
        if (lows > 1) begin
            m_conf = 1'b1;
        end else if (lows == 1) begin
            r = lookup(v[6:0]);
            if (r == -1) begin
                m_valid[pos] = 1'b0;
                m_upd = 1'b1;
                m_idx = IW'(pos);
            end else if (r >= 0) begin
                m_dig[pos]   = 4'(r);
                m_valid[pos] = 1'b1;
                m_upd = 1'b1;
                m_idx = IW'(pos);
            end else begin
                m_err[pos] = 1'b1;
            end
        end
    endtask

    // A pattern seen on S+1 consecutive edges commits two edges later.
    task automatic model_edge();
        samp_t cur;
        samp_t old;
        cur.v = {an_n, seg_n};
        if (cur.v == last_v) begin
            if (last_run < 100000) last_run++;
        end else begin
            last_run = 1;
        end
        last_v  = cur.v;
        cur.run = last_run;
        pipe.push_back(cur);
        old = pipe.pop_front();
        m_upd = 1'b0;
        if (clear) begin
            for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
            m_valid = '0;
            m_err   = '0;
            m_conf  = 1'b0;
        end else if (old.run == S + 1) begin
            model_apply(old.v);
        end
    endtask

    task automatic check1(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4*N-1:0] ed;
        for (int i = 0; i < N; i++) ed[4*i +: 4] = m_dig[i];
        check1("digits", 32'(digits), 32'(ed));
        check1("digit_valid", 32'(digit_valid), 32'(m_valid));
        check1("digit_err", 32'(digit_err), 32'(m_err));
        check1("conflict", 32'(conflict), 32'(m_conf));
        check1("upd", 32'(upd), 32'(m_upd));
        check1("upd_idx", 32'(upd_idx), 32'(m_idx));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input int n);
        upd_cnt    = 0;
        first_edge = 0;
        idxq.delete();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (upd === 1'b1) begin
                upd_cnt++;
                if (first_edge == 0) first_edge = k;
                idxq.push_back(upd_idx);
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [6:0] s);
        an_n  = a;
        seg_n = s;
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        drive('1, '1);
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst = 1'b0;

        // single digit, latency
        drive(4'b1110, 7'b0100100);
        hold(20);
        check1("t1_first_upd_edge", 32'(first_edge), 32'd11);
        check1("t1_upd_count", 32'(upd_cnt), 32'd1);
        check1("t1_digit0", 32'(digits[3:0]), 32'h2);
        check1("t1_valid", 32'(digit_valid), 32'b0001);

        // scan all positions
        upd_cnt = 0;
        begin
            logic [6:0] sp4 [4];
            int tot;
            logic [IW-1:0] got [$];
            sp4 = '{7'b1111001, 7'b1000000, 7'b1000110, 7'b0000110};
            tot = 0;
            for (int p = 0; p < 4; p++) begin
                drive(~(N'(1) << p), sp4[p]);
                hold(20);
                tot += upd_cnt;
                foreach (idxq[j]) got.push_back(idxq[j]);
            end
            check1("t2_upd_count", 32'(tot), 32'd4);
            check1("t2_digits", 32'(digits), 32'hEC01);
            check1("t2_valid", 32'(digit_valid), 32'hF);
            for (int j = 0; j < got.size() && j < 4; j++) begin
                check1("t2_upd_idx_seq", 32'(got[j]), 32'(j));
            end
        end

        // illegal pattern
        drive(4'b1101, 7'b1010101);
        hold(20);
        check1("t3_err", 32'(digit_err), 32'b0010);
        check1("t3_upd_count", 32'(upd_cnt), 32'd0);
        check1("t3_digits", 32'(digits), 32'hEC01);
        check1("t3_valid", 32'(digit_valid), 32'hF);

        // fast refresh never commits
        begin
            int tot = 0;
            for (int t = 0; t < 6; t++) begin
                drive(4'b1110, (t % 2 == 0) ? 7'b0110000 : 7'b0011001);
                hold(5);
                tot += upd_cnt;
            end
            check1("t4_fast_upd_count", 32'(tot), 32'd0);
            check1("t4_fast_digits", 32'(digits), 32'hEC01);
        end
        drive(4'b1110, 7'b0010010);
        hold(12);
        check1("t4_hold_upd_count", 32'(upd_cnt), 32'd1);
        check1("t4_digit0", 32'(digits[3:0]), 32'h5);

        // conflict then clear
        drive(4'b1100, 7'b1000000);
        hold(20);
        check1("t5_conflict", 32'(conflict), 32'd1);
        check1("t5_upd_count", 32'(upd_cnt), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check1("t5_clr_conflict", 32'(conflict), 32'd0);
        check1("t5_clr_digits", 32'(digits), 32'd0);
        check1("t5_clr_valid", 32'(digit_valid), 32'd0);
        hold(20);
        check1("t5_no_recommit", 32'(upd_cnt), 32'd0);

        // reset mid-window
        drive(4'b1110, 7'b0110000);
        hold(8);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        tick();
        rst = 1'b0;
        hold(20);
        check1("t6_first_upd_edge", 32'(first_edge), 32'd11);
        check1("t6_digit0", 32'(digits[3:0]), 32'h3);

        // random traffic
        for (int it = 0; it < 250; it++) begin
            int r;
            int p;
            logic [N-1:0] a;
            logic [6:0] s;
            r = int'($urandom_range(0, 9));
            p = int'($urandom_range(0, N - 1));
            if (r == 0) begin
                a = '1;
            end else if (r == 1) begin
                a = ~((N'(1) << p) | (N'(1) << ((p + 1) % N)));
            end else begin
                a = ~(N'(1) << p);
            end
            r = int'($urandom_range(0, 9));
            if (r < 7) s = pats[$urandom_range(0, 16)];
            else if (r == 7) s = 7'b1111111;
            else s = 7'($urandom);
            drive(a, s);
            if ($urandom_range(0, 14) == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            hold(int'($urandom_range(2, 20)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Reverse path of the board's seven-segment display drive: monitors multiplexed, active-low segment and digit-enable lines and recovers the hex digit shown on each position.
- Used as a bench/self-check block: observes the display bus driven by the design under test and exposes the recovered nibbles, valid, error and conflict flags, and an update strobe.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 8, consecutive clocks the synchronized {an_n, seg_n} must hold before capture (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of captured state.
- seg_n  in  7  segment lines, active-low; bit0=a … bit6=g.
- an_n  in  NUM_DIGITS  digit enables, active-low; bit i selects position i.
- digits  out  4*NUM_DIGITS  recovered nibbles; position i in bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  position holds a decoded digit.
- digit_err  out  NUM_DIGITS  sticky: illegal pattern captured on position.
- conflict  out  1  sticky: stable window with more than one enable low.
- upd  out  1  one-cycle pulse on each commit.
- upd_idx  out  max(1,clog2(NUM_DIGITS))  position of the latest commit.

Behaviour:
- Reset (async): digits=0, digit_valid=0, digit_err=0, conflict=0, upd=0, upd_idx=0; synchronizer and previous-sample registers load all-ones (blank, no enable); stability counter=0.
- Input path: seg_n and an_n pass through a 2-flop synchronizer (s1, s2), then a previous-sample register (sp).
- Stability counter cnt: if s2!=sp then cnt<=0; else if cnt<STABLE_CYCLES then cnt<=cnt+1; it saturates at STABLE_CYCLES.
- Commit event fires on the edge where cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES. That is exactly once per stable window.
- Latency: an input held after a change commits on the (STABLE_CYCLES+3)th rising edge after the change (11 edges at default). A change before then restarts the count.
- Commit, exactly one an_n bit low (position i):
  - legal pattern: digits[i]<=code, digit_valid[i]<=1, upd<=1, upd_idx<=i.
  - 1111111 (blank): digit_valid[i]<=0, digits[i] held, upd<=1, upd_idx<=i.
  - any other pattern: digit_err[i]<=1, digits[i] and digit_valid[i] held, upd<=0.
- Commit, no an_n bit low: no state change.
- Commit, two or more an_n bits low: conflict<=1, no digit state change.
- Legal patterns (seg_n bits 6..0 -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5
  - 1000010->6, 0000010->6, 1111000->7, 0000000->8, 0010000->9
  - 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F
- upd is high for exactly one cycle per legal or blank commit; it is otherwise 0. upd_idx holds its value between commits.
- clear: on the next edge, digits, digit_valid, digit_err, conflict<=0 and upd<=0. clear wins over a commit in the same cycle; that commit is lost. cnt is unaffected, so the held pattern does not recommit until the inputs change.
- Reset mid-window: all state returns to reset values; capture restarts from blank.
- Refresh rates faster than STABLE_CYCLES+1 clocks per digit never commit; this is required behaviour, not an error.

Test Plan:
- Reset, then an_n=1110, seg_n=0100100 held -> upd pulses on edge 11, upd_idx=0, digits[3:0]=2, digit_valid=0001.
- Scan positions 0..3 with 1, 0, 1000110, 0000110, 20 clocks each -> digits=16'hEC01, digit_valid=1111, four upd pulses with idx 0,1,2,3.
- an_n=1101, seg_n=1010101 held 20 clocks -> digit_err=0010, no upd, digits/valid of position 1 unchanged.
- Pattern toggles every 5 clocks (STABLE_CYCLES=8) -> no upd, outputs unchanged; then hold 12 clocks -> exactly one commit.
- an_n=1100 held 20 clocks -> conflict=1, no upd; clear pulse -> conflict=0, digits=0, digit_valid=0.
- Assert rst mid-count (cnt=5) and deassert with the same pattern held -> outputs 0 during reset, commit 11 edges after release.
